// File: rtl/w0rm_bus_pkg.sv
// Shared types and constants for the w0rm data-bus RAM slave.
package w0rm_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_e;

    localparam int unsigned CNT_WIDTH = 4;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/w0rm_data_bus_ram_if.sv
// Request/response bundle between a bus master and the RAM slave.
interface w0rm_data_bus_ram_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  bus_write_in;
    logic                  bus_read_in;
    logic                  bus_valid_in;
    logic [ADDR_WIDTH-1:0] bus_addr_in;
    logic [DATA_WIDTH-1:0] bus_data_in;
    logic [DATA_WIDTH-1:0] bus_data_out;
    logic                  bus_valid_out;
    logic                  bus_error_out;
    logic                  busy;

    modport master (
        output bus_write_in, bus_read_in, bus_valid_in, bus_addr_in, bus_data_in,
        input  bus_data_out, bus_valid_out, bus_error_out, busy
    );

    modport slave (
        input  bus_write_in, bus_read_in, bus_valid_in, bus_addr_in, bus_data_in,
        output bus_data_out, bus_valid_out, bus_error_out, busy
    );
endinterface

// File: rtl/w0rm_sync_ram.sv
// Single-port RAM: synchronous write, combinational read. Contents survive reset.
module w0rm_sync_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [0:(2**DEPTH_LOG2)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/w0rm_data_bus_ram.sv
// Bus slave wrapping a word RAM: decodes a base-aligned window, inserts
// WAIT_STATES cycles, then issues a one-cycle registered completion.
module w0rm_data_bus_ram
    import w0rm_bus_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           DEPTH_LOG2  = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = {ADDR_WIDTH{1'b0}},
    parameter int unsigned           WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    w0rm_data_bus_ram_if.slave   bus
);
    localparam int unsigned           LP_TAG_LSB  = DEPTH_LOG2 + 2;
    localparam logic [ADDR_WIDTH-1:0] LP_BASE     = BASE_ADDR;
    localparam bit                    LP_HAS_WAIT = (WAIT_STATES != 0);
    localparam logic [CNT_WIDTH-1:0]  LP_CNT_INIT =
        CNT_WIDTH'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    state_e                r_state, w_next_state;
    logic [CNT_WIDTH-1:0]  r_cnt, w_next_cnt;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_valid_out, r_error_out, r_busy;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic                  w_capture, w_enter_resp, w_hit, w_ram_we, w_req_write;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [DEPTH_LOG2-1:0] w_ram_idx;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // In IDLE the live bus request is decoded so a zero-wait access can respond next cycle
    assign w_req_write = (r_state == IDLE) ? bus.bus_write_in : r_write;
    assign w_req_addr  = (r_state == IDLE) ? bus.bus_addr_in  : r_addr;
    assign w_hit       = (w_req_addr[ADDR_WIDTH-1:LP_TAG_LSB] == LP_BASE[ADDR_WIDTH-1:LP_TAG_LSB])
                         && is_word_aligned(w_req_addr[1:0]);
    assign w_ram_idx   = w_req_addr[LP_TAG_LSB-1:2];
    assign w_ram_we    = (r_state == RESPOND) && r_write && w_hit;

    w0rm_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Next-state and wait-counter logic
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.bus_valid_in && (bus.bus_write_in || bus.bus_read_in)) begin
                    w_capture = 1'b1;
                    if (LP_HAS_WAIT) begin
                        w_next_state = WAIT;
                        w_next_cnt   = LP_CNT_INIT;
                    end else begin
                        w_next_state = RESPOND;
                        w_next_cnt   = {CNT_WIDTH{1'b0}};
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == {CNT_WIDTH{1'b0}}) begin
                    w_next_state = RESPOND;
                end else begin
                    w_next_cnt = r_cnt - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            RESPOND: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = {CNT_WIDTH{1'b0}};
            end
        endcase
    end

    assign w_enter_resp = (w_next_state == RESPOND);

    // State, captured request and registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= {CNT_WIDTH{1'b0}};
            r_write     <= 1'b0;
            r_addr      <= {ADDR_WIDTH{1'b0}};
            r_wdata     <= {DATA_WIDTH{1'b0}};
            r_valid_out <= 1'b0;
            r_error_out <= 1'b0;
            r_data_out  <= {DATA_WIDTH{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            if (w_capture) begin
                r_write <= bus.bus_write_in;
                r_addr  <= bus.bus_addr_in;
                r_wdata <= bus.bus_data_in;
            end
            r_valid_out <= w_enter_resp;
            r_error_out <= w_enter_resp && !w_hit;
            r_data_out  <= (w_enter_resp && w_hit && !w_req_write) ? w_ram_rdata
                                                                   : {DATA_WIDTH{1'b0}};
            r_busy      <= (w_next_state != IDLE);
        end
    end

    assign bus.bus_valid_out = r_valid_out;
    assign bus.bus_error_out = r_error_out;
    assign bus.bus_data_out  = r_data_out;
    assign bus.busy          = r_busy;
endmodule

// File: tb/tb_w0rm_data_bus_ram.sv
// Scoreboard bench: two slaves (0 and 3 wait states) driven with directed and
// random requests; a per-cycle monitor checks every completion against a word model.
module tb_w0rm_data_bus_ram;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DL = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    w0rm_data_bus_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    w0rm_data_bus_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();

    logic        t_wr [2], t_rd [2], t_vld [2];
    logic [31:0] t_addr [2], t_data [2];
    logic        o_vld [2], o_err [2], o_busy [2];
    logic [31:0] o_data [2];

    assign if0.bus_write_in = t_wr[0];   assign if3.bus_write_in = t_wr[1];
    assign if0.bus_read_in  = t_rd[0];   assign if3.bus_read_in  = t_rd[1];
    assign if0.bus_valid_in = t_vld[0];  assign if3.bus_valid_in = t_vld[1];
    assign if0.bus_addr_in  = t_addr[0]; assign if3.bus_addr_in  = t_addr[1];
    assign if0.bus_data_in  = t_data[0]; assign if3.bus_data_in  = t_data[1];
    assign o_vld[0]  = if0.bus_valid_out; assign o_vld[1]  = if3.bus_valid_out;
    assign o_err[0]  = if0.bus_error_out; assign o_err[1]  = if3.bus_error_out;
    assign o_data[0] = if0.bus_data_out;  assign o_data[1] = if3.bus_data_out;
    assign o_busy[0] = if0.busy;          assign o_busy[1] = if3.busy;

    w0rm_data_bus_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL),
                        .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

    w0rm_data_bus_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL),
                        .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] mdl [2][1024];
    int          ws_of    [2] = '{0, 3};
    int          busy_run [2] = '{0, 0};
    int          resp_cnt [2] = '{0, 0};

    // Window is [0, 4 KiB) with word alignment
    function automatic logic is_hit(input logic [31:0] a);
        return (a < 32'h0000_1000) && (a % 4 == 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic qpush(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (o_busy[d] === 1'b1) busy_run[d]++;
        else                    busy_run[d] = 0;
        if (o_vld[d] === 1'b1) begin
            resp_cnt[d]++;
            if (qsize(d) == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp dut%0d: got data %h err %b expected no response",
                         d, o_data[d], o_err[d]);
            end else begin
                e = qpop(d);
                check($sformatf("resp_data_dut%0d", d), o_data[d], e.data);
                check($sformatf("resp_err_dut%0d", d), {31'd0, o_err[d]}, {31'd0, e.err});
                check($sformatf("latency_dut%0d", d), cyc - e.acc + 1, ws_of[d] + 1);
                check($sformatf("busy_span_dut%0d", d), busy_run[d], ws_of[d] + 1);
            end
        end else begin
            check($sformatf("idle_data_dut%0d", d), o_data[d], 32'd0);
            check($sformatf("idle_err_dut%0d", d), {31'd0, o_err[d]}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic wait_idle(input int d);
        int n = 0;
        while (o_busy[d] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout_dut%0d: busy still %b, required 0", d, o_busy[d]);
        end
    endtask

    // Issue one real request; expectation is computed from the word model at accept time
    task automatic issue(input int d, input logic wr, input logic rd,
                         input logic [31:0] a, input logic [31:0] dat);
        exp_t e;
        int   idx;
        wait_idle(d);
        t_wr[d] = wr; t_rd[d] = rd; t_addr[d] = a; t_data[d] = dat; t_vld[d] = 1'b1;
        @(posedge clk); #1;
        t_vld[d] = 1'b0;
        idx   = int'(a[11:2]);
        e.acc = cyc;
        e.err = !is_hit(a);
        if (is_hit(a) && wr) begin
            e.data     = 32'd0;
            mdl[d][idx] = dat;
        end else if (is_hit(a)) begin
            e.data = mdl[d][idx];
        end else begin
            e.data = 32'd0;
        end
        qpush(d, e);
        @(negedge clk);
    endtask

    task automatic pulse(input int d, input logic wr, input logic rd, input logic [31:0] a);
        t_wr[d] = wr; t_rd[d] = rd; t_addr[d] = a; t_data[d] = 32'hFFFF_FFFF; t_vld[d] = 1'b1;
        @(posedge clk); #1;
        t_vld[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          rc;
        logic [1:0]  op;
        logic [31:0] a;
        int          d, r;
        for (int i = 0; i < 2; i++) begin
            t_wr[i] = 1'b0; t_rd[i] = 1'b0; t_vld[i] = 1'b0;
            t_addr[i] = 32'd0; t_data[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", {31'd0, o_vld[i]}, 32'd0);
            check("rst_busy", {31'd0, o_busy[i]}, 32'd0);
            check("rst_data", o_data[i], 32'd0);
            check("rst_err", {31'd0, o_err[i]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 16; k++)
                issue(i, 1'b1, 1'b0, 32'(k * 4), $urandom);

        // Write-then-read, decode errors, both-set treated as write
        for (int i = 0; i < 2; i++) begin
            issue(i, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
            issue(i, 1'b0, 1'b1, 32'h10, 32'd0);
            check("deadbeef_model", mdl[i][4], 32'hDEAD_BEEF);
            issue(i, 1'b0, 1'b1, 32'h0000_1000, 32'd0);
            issue(i, 1'b1, 1'b0, 32'h0000_0002, 32'hFFFF_FFFF);
            issue(i, 1'b0, 1'b1, 32'h0, 32'd0);
            issue(i, 1'b1, 1'b1, 32'h4, 32'hA5A5_A5A5);
            issue(i, 1'b0, 1'b1, 32'h4, 32'd0);
        end

        // Request pulses while busy, and strobes with no operation, are ignored
        for (int i = 0; i < 2; i++) begin
            wait_idle(i);
            rc = resp_cnt[i];
            issue(i, 1'b0, 1'b1, 32'h10, 32'd0);
            pulse(i, 1'b1, 1'b0, 32'h10);
            wait_idle(i);
            @(negedge clk);
            check("single_resp", resp_cnt[i] - rc, 32'd1);
            pulse(i, 1'b0, 1'b0, 32'h10);
            check("noop_busy", {31'd0, o_busy[i]}, 32'd0);
        end

        // Reset during the wait phase of a write aborts it
        wait_idle(1);
        rc = resp_cnt[1];
        t_wr[1] = 1'b1; t_rd[1] = 1'b0; t_addr[1] = 32'h20; t_data[1] = 32'h1234_5678;
        t_vld[1] = 1'b1;
        @(posedge clk); #1;
        t_vld[1] = 1'b0;
        @(negedge clk);
        check("abort_busy_before", {31'd0, o_busy[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy_in_rst", {31'd0, o_busy[1]}, 32'd0);
        check("abort_valid_in_rst", {31'd0, o_vld[1]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_resp", resp_cnt[1] - rc, 32'd0);
        issue(1, 1'b0, 1'b1, 32'h20, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 160; n++) begin
            d  = $urandom_range(0, 1);
            r  = $urandom_range(0, 9);
            op = 2'($urandom_range(1, 3));
            if (r < 6)       a = 32'($urandom_range(0, 15) * 4);
            else if (r < 8)  a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else             a = $urandom | 32'h0000_1000;
            issue(d, op[0], op[1], a, $urandom);
            if ($urandom_range(0, 7) == 0) pulse(d, 1'b1, 1'b1, 32'h8);
        end

        for (int n = 0; n < 50 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clk);
        check("drain_q0", q0.size(), 32'd0);
        check("drain_q1", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/w0rm_data_bus_ram.md
W0RM_DATA_BUS_RAM -- requirements
Module: w0rm_data_bus_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning bus address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning bus data width and RAM word width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of RAM depth in words.
REQ-004 SHALL have parameter BASE_ADDR, default 0, meaning byte base address of the RAM window, aligned to 2^(DEPTH_LOG2+2).
REQ-005 SHALL have parameter WAIT_STATES, default 0, range 0..15, meaning extra cycles inserted before each response.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port bus_write_in, input, 1 bit: request is a write.
REQ-009 SHALL have port bus_read_in, input, 1 bit: request is a read.
REQ-010 SHALL have port bus_valid_in, input, 1 bit: single-cycle request strobe.
REQ-011 SHALL have port bus_addr_in, input, ADDR_WIDTH bits: byte address.
REQ-012 SHALL have port bus_data_in, input, DATA_WIDTH bits: write data.
REQ-013 SHALL have port bus_data_out, output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port bus_valid_out, output, 1 bit: single-cycle completion strobe.
REQ-015 SHALL have port bus_error_out, output, 1 bit: completion was a decode error; qualified by bus_valid_out.
REQ-016 SHALL have port busy, output, 1 bit: a request is in progress.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESPOND.
REQ-018 In IDLE, SHALL accept a request when bus_valid_in=1 and (bus_write_in|bus_read_in)=1, capture write/read/addr/data, and go to WAIT if WAIT_STATES>0, otherwise to RESPOND.
REQ-019 In IDLE, SHALL ignore bus_valid_in with neither read nor write set: no response, no state change.
REQ-020 In WAIT, SHALL count captured cycles from WAIT_STATES-1 down to 0, then go to RESPOND; bus inputs are ignored.
REQ-021 In RESPOND, SHALL assert bus_valid_out=1 for exactly one cycle, then return to IDLE.
REQ-022 Latency SHALL be WAIT_STATES+1 cycles from the accepting edge to the bus_valid_out cycle.
REQ-023 SHALL decode a hit when addr[ADDR_WIDTH-1:DEPTH_LOG2+2] equals the same bits of BASE_ADDR and addr[1:0]=0; the word index is addr[DEPTH_LOG2+1:2].
REQ-024 A hit read SHALL return RAM[index] on bus_data_out with bus_error_out=0.
REQ-025 A hit write SHALL commit bus_data_in to RAM[index] on the RESPOND edge and return bus_data_out=0.
REQ-026 A miss or misaligned access SHALL still complete with bus_valid_out=1, bus_error_out=1, bus_data_out=0, and no RAM write.
REQ-027 With read and write both set, SHALL treat the request as a write.
REQ-028 A read issued after a completed write to the same index SHALL return the new value.
REQ-029 bus_valid_in while busy=1 SHALL be ignored with no queuing.
REQ-030 busy SHALL be 1 in WAIT and RESPOND and 0 in IDLE.
REQ-031 bus_data_out and bus_error_out SHALL be 0 whenever bus_valid_out=0.

Reset
REQ-032 While rst_n=0, SHALL force IDLE, counter=0, bus_valid_out=0, bus_error_out=0, bus_data_out=0, busy=0.
REQ-033 Reset mid-operation SHALL abort the request with no response and no RAM write.
REQ-034 Reset SHALL NOT clear RAM contents.

Structure
REQ-035 Shared package w0rm_bus_pkg SHALL hold the FSM state type and the WAIT_STATES counter width constant (4).
REQ-036 SHALL instantiate one sub-module, w0rm_sync_ram: single-port RAM of DATA_WIDTH x 2^DEPTH_LOG2 with synchronous write, combinational or registered read, timed so that REQ-022 still holds.

Verification
REQ-037 Verification SHALL cover: WAIT_STATES=0, write 0xDEADBEEF at 0x10, then read 0x10 -> write response 1 cycle later with data 0; read returns 0xDEADBEEF, error=0.
REQ-038 Verification SHALL cover: WAIT_STATES=3, read 0x10 -> bus_valid_out exactly 4 cycles after accept, busy=1 for those 4 cycles.
REQ-039 Verification SHALL cover: BASE_ADDR=0, DEPTH_LOG2=10, read 0x00001000 and write 0x00000002 -> each completes with error=1 and data 0; RAM word 0 unchanged.
REQ-040 Verification SHALL cover: second bus_valid_in pulse while busy -> ignored; exactly one bus_valid_out.
REQ-041 Verification SHALL cover: rst_n low during WAIT of a write 0x12345678 to 0x20 -> no bus_valid_out; a later read of 0x20 returns the prior value.
REQ-042 Verification SHALL cover: read and write both set, data 0xA5A5A5A5 at 0x4 -> handled as a write; a later read of 0x4 returns 0xA5A5A5A5.
